sha1_core: RTL

// Iterative SHA-1 compression engine: takes one 512-bit padded message block, runs
// all 80 rounds with ROUNDS_PER_CYCLE rounds unrolled per clock, and returns the
// 160-bit chained digest. Sits between the message padder and the digest consumer.

---
 rtl/sha1_core.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/sha1_core.sv
// Iterative SHA-1 compression core: one 512-bit block in, 160-bit chained digest out,
// ROUNDS_PER_CYCLE rounds per clock. Define SHA1_BSWAP_EN to byte-reverse input words.
module sha1_core #(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [511:0] in_block,
    input  logic         in_first,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [159:0] out_digest
);
    localparam int R = ROUNDS_PER_CYCLE;
    localparam logic [31:0] IV [0:4] = '{32'h67452301, 32'hefcdab89, 32'h98badcfe,
                                         32'h10325476, 32'hc3d2e1f0};

    typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;

    if (R != 1 && R != 2 && R != 4 && R != 5 && R != 10 && R != 20) begin : g_bad_rounds
        $error("sha1_core: ROUNDS_PER_CYCLE=%0d is not one of 1,2,4,5,10,20", R);
    end

    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [31:0] round_f(input logic [6:0] tt, input logic [31:0] b,
                                            input logic [31:0] c, input logic [31:0] d);
        if (tt < 7'd20)      return (b & c) | (~b & d);
        else if (tt < 7'd40) return b ^ c ^ d;
        else if (tt < 7'd60) return (b & c) | (b & d) | (c & d);
        else                 return b ^ c ^ d;
    endfunction

    function automatic logic [31:0] round_k(input logic [6:0] tt);
        if (tt < 7'd20)      return 32'h5a827999;
        else if (tt < 7'd40) return 32'h6ed9eba1;
        else if (tt < 7'd60) return 32'h8f1bbcdc;
        else                 return 32'hca62c1d6;
    endfunction

`ifdef SHA1_BSWAP_EN
    function automatic logic [31:0] in_word(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction
`else
    function automatic logic [31:0] in_word(input logic [31:0] w);
        return w;
    endfunction
`endif

    state_t      state, state_next;
    logic [6:0]  t;
    logic        last;
    logic [31:0] wbuf [0:15];
    logic [31:0] va, vb, vc, vd, ve;
    logic [31:0] h [0:4];

    // wx extends the 16-word window by the R schedule words this cycle may need
    logic [31:0] wx [0:15+R];
    logic [31:0] ca [0:R];
    logic [31:0] cb [0:R];
    logic [31:0] cc [0:R];
    logic [31:0] cd [0:R];
    logic [31:0] ce [0:R];

    for (genvar i = 0; i < 16; i++) begin : g_win
        assign wx[i] = wbuf[i];
    end
    for (genvar i = 16; i < 16 + R; i++) begin : g_sched
        assign wx[i] = rotl(wx[i-3] ^ wx[i-8] ^ wx[i-14] ^ wx[i-16], 1);
    end

    assign ca[0] = va;
    assign cb[0] = vb;
    assign cc[0] = vc;
    assign cd[0] = vd;
    assign ce[0] = ve;

    for (genvar j = 0; j < R; j++) begin : g_round
        logic [6:0]  tj;
        logic [31:0] temp;
        assign tj        = t + 7'(j);
        assign temp      = rotl(ca[j], 5) + round_f(tj, cb[j], cc[j], cd[j]) + ce[j]
                         + round_k(tj) + wx[j];
        assign ca[j+1]   = temp;
        assign cb[j+1]   = ca[j];
        assign cc[j+1]   = rotl(cb[j], 30);
        assign cd[j+1]   = cc[j];
        assign ce[j+1]   = cd[j];
    end

    assign last = (t == 7'(80 - R));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = ROUND;
            ROUND:   if (last) state_next = FINAL;
            FINAL:   state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready   = (state == IDLE);
        out_valid  = (state == DONE);
        out_digest = '0;
        if (state == DONE) out_digest = {h[0], h[1], h[2], h[3], h[4]};
    end

    // Chaining value and round counter: reset to IV / 0
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 5; i++) h[i] <= IV[i];
            t <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    t <= '0;
                    if (in_first) for (int i = 0; i < 5; i++) h[i] <= IV[i];
                end
                ROUND: t <= last ? 7'd0 : t + 7'(R);
                FINAL: begin
                    h[0] <= h[0] + va;
                    h[1] <= h[1] + vb;
                    h[2] <= h[2] + vc;
                    h[3] <= h[3] + vd;
                    h[4] <= h[4] + ve;
                end
                default: ;
            endcase
        end
    end

    // Working variables and message window carry no reset; they are reloaded on accept
    always_ff @(posedge clk) begin
        if (state == IDLE && in_valid) begin
            for (int i = 0; i < 16; i++) wbuf[i] <= in_word(in_block[511-32*i -: 32]);
            if (in_first) begin
                va <= IV[0]; vb <= IV[1]; vc <= IV[2]; vd <= IV[3]; ve <= IV[4];
            end else begin
                va <= h[0];  vb <= h[1];  vc <= h[2];  vd <= h[3];  ve <= h[4];
            end
        end else if (state == ROUND) begin
            for (int i = 0; i < 16; i++) wbuf[i] <= wx[i+R];
            va <= ca[R];
            vb <= cb[R];
            vc <= cc[R];
            vd <= cd[R];
            ve <= ce[R];
        end
    end
endmodule
